// File: rtl/id_defs_pkg.sv
// Shared decode definitions for the LEGv8 ID stage: opcode tables, immediate
// format classification and default special-register indices.
package id_defs_pkg;

  localparam int unsigned DEF_ZR_IDX = 31;
  localparam int unsigned DEF_LR_IDX = 30;

  // Opcode field values, compared against the instruction MSBs
  localparam logic [4:0] OPC_B      = 5'b00101;     // inst[30:26], B and BL
  localparam logic [6:0] OPC_CB_Z   = 7'b1011010;   // inst[31:25], CBZ/CBNZ
  localparam logic [6:0] OPC_CB_CND = 7'b0101010;   // inst[31:25], B.cond
  localparam logic [7:0] OPC_D      = 8'b11111000;  // inst[31:24], LDUR/STUR

  localparam int unsigned NUM_I_OPC = 8;
  localparam logic [9:0] I_OPC [NUM_I_OPC] = '{
    10'b1001000100,  // ADDI
    10'b1011000100,  // ADDIS
    10'b1101000100,  // SUBI
    10'b1111000100,  // SUBIS
    10'b1001001000,  // ANDI
    10'b1111001000,  // ANDIS
    10'b1011001000,  // ORRI
    10'b1101001000   // EORI
  };

  localparam int unsigned NUM_IW_OPC = 2;
  localparam logic [8:0] IW_OPC [NUM_IW_OPC] = '{
    9'b110100101,    // MOVZ
    9'b111100101     // MOVK
  };

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_B,
    IMM_CB,
    IMM_D,
    IMM_I,
    IMM_IW
  } imm_type_e;

  // Immediate format of an instruction; earlier formats take precedence.
  function automatic imm_type_e classify_imm(input logic [31:0] inst);
    imm_type_e t;
    t = IMM_NONE;
    if (inst[30:26] == OPC_B) begin
      t = IMM_B;
    end else if (inst[31:25] == OPC_CB_Z || inst[31:25] == OPC_CB_CND) begin
      t = IMM_CB;
    end else if (inst[31:24] == OPC_D) begin
      t = IMM_D;
    end else begin
      for (int unsigned i = 0; i < NUM_I_OPC; i++) begin
        if (inst[31:22] == I_OPC[i]) t = IMM_I;
      end
      for (int unsigned i = 0; i < NUM_IW_OPC; i++) begin
        if (t == IMM_NONE && inst[31:23] == IW_OPC[i]) t = IMM_IW;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: 2 combinational read ports, 1 write port, zero
// register hard-wired. ID_WB_BYPASS_EN makes same-cycle reads write-through.
module id_regfile
  import id_defs_pkg::*;
#(
  parameter  int unsigned WORD     = 64,
  parameter  int unsigned NUM_REGS = 32,
  parameter  int unsigned ZR_IDX   = DEF_ZR_IDX,
  localparam int unsigned RW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   raddr1,
  input  logic [RW-1:0]   raddr2,
  output logic [WORD-1:0] rdata1_c,
  output logic [WORD-1:0] rdata2_c,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [WORD-1:0] wdata
);

  logic [WORD-1:0] regs_q [NUM_REGS];
  logic [WORD-1:0] regs_d [NUM_REGS];
  logic            wr_en_c;

  assign wr_en_c = we && (waddr != RW'(ZR_IDX));

  always_comb begin
    regs_d = regs_q;
    if (wr_en_c) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Zero register override is applied last so it also wins over the bypass
  always_comb begin
    rdata1_c = regs_q[raddr1];
    rdata2_c = regs_q[raddr2];
`ifdef ID_WB_BYPASS_EN
    if (wr_en_c && waddr == raddr1) rdata1_c = wdata;
    if (wr_en_c && waddr == raddr2) rdata2_c = wdata;
`endif
    if (raddr1 == RW'(ZR_IDX)) rdata1_c = '0;
    if (raddr2 == RW'(ZR_IDX)) rdata2_c = '0;
  end

endmodule

// File: rtl/id_pipe_stage.sv
// LEGv8 instruction-decode stage: register read, immediate generation, load-use
// stall and ID/EX register with valid/ready. Optional macro: ID_WB_BYPASS_EN.
module id_pipe_stage
  import id_defs_pkg::*;
#(
  parameter  int unsigned WORD      = 64,
  parameter  int unsigned NUM_REGS  = 32,
  parameter  int unsigned ZR_IDX    = DEF_ZR_IDX,
  parameter  int unsigned LR_IDX    = DEF_LR_IDX,
  parameter  int unsigned INST_SIZE = 32,
  localparam int unsigned RW        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INST_SIZE-1:0] inst,
  input  logic [WORD-1:0]      pc,
  input  logic                 Reg2Loc,
  input  logic                 wb_RegWrite,
  input  logic                 wb_WRegLoc,
  input  logic [RW-1:0]        wb_reg,
  input  logic [WORD-1:0]      wb_data,
  input  logic                 ex_MemRead,
  input  logic [RW-1:0]        ex_rd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_pc,
  output logic [WORD-1:0]      out_r_data1,
  output logic [WORD-1:0]      out_r_data2,
  output logic [WORD-1:0]      out_ex_data,
  output logic [RW-1:0]        out_rs1,
  output logic [RW-1:0]        out_rs2,
  output logic [RW-1:0]        out_rd,
  output logic                 stall
);

  logic [RW-1:0]   rs1_c, rs2_c, rd_c;
  logic [WORD-1:0] rdata1_c, rdata2_c;
  logic [WORD-1:0] imm_c;
  imm_type_e       imm_type_c;
  logic [RW-1:0]   wb_tgt_c;
  logic            wb_we_c;
  logic            stall_c, ready_c, capture_c;

  logic            valid_q,   valid_d;
  logic [WORD-1:0] pc_q,      pc_d;
  logic [WORD-1:0] r_data1_q, r_data1_d;
  logic [WORD-1:0] r_data2_q, r_data2_d;
  logic [WORD-1:0] ex_data_q, ex_data_d;
  logic [RW-1:0]   rs1_q,     rs1_d;
  logic [RW-1:0]   rs2_q,     rs2_d;
  logic [RW-1:0]   rd_q,      rd_d;

  // Register index fields
  always_comb begin
    rs1_c = RW'(inst[9:5]);
    rs2_c = Reg2Loc ? RW'(inst[4:0]) : RW'(inst[20:16]);
    rd_c  = RW'(inst[4:0]);
  end

  assign wb_tgt_c = wb_WRegLoc ? RW'(LR_IDX) : wb_reg;
  assign wb_we_c  = wb_RegWrite && (wb_tgt_c != RW'(ZR_IDX));

  id_regfile #(
    .WORD     (WORD),
    .NUM_REGS (NUM_REGS),
    .ZR_IDX   (ZR_IDX)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (rs1_c),
    .raddr2   (rs2_c),
    .rdata1_c (rdata1_c),
    .rdata2_c (rdata2_c),
    .we       (wb_we_c),
    .waddr    (wb_tgt_c),
    .wdata    (wb_data)
  );

  // Immediate generation; signed formats are branch/memory offsets
  assign imm_type_c = classify_imm(inst[31:0]);

  always_comb begin
    imm_c = '0;
    case (imm_type_c)
      IMM_B:   imm_c = WORD'($signed(inst[25:0]));
      IMM_CB:  imm_c = WORD'($signed(inst[23:5]));
      IMM_D:   imm_c = WORD'($signed(inst[20:12]));
      IMM_I:   imm_c = WORD'(inst[21:10]);
      IMM_IW:  imm_c = WORD'(inst[20:5]);
      default: imm_c = '0;
    endcase
  end

  // Load-use hazard: conservatively assumes rs2 is always read
  always_comb begin
    stall_c = in_valid && ex_MemRead && (ex_rd != RW'(ZR_IDX)) &&
              ((ex_rd == rs1_c) || (ex_rd == rs2_c));
    ready_c   = !flush && !stall_c && (!valid_q || out_ready);
    capture_c = in_valid && ready_c;
  end

  assign stall    = stall_c;
  assign in_ready = ready_c;

  // ID/EX next state: flush > capture > drain > hold
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    r_data1_d = r_data1_q;
    r_data2_d = r_data2_q;
    ex_data_d = ex_data_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture_c) begin
      valid_d   = 1'b1;
      pc_d      = pc;
      r_data1_d = rdata1_c;
      r_data2_d = rdata2_c;
      ex_data_d = imm_c;
      rs1_d     = rs1_c;
      rs2_d     = rs2_c;
      rd_d      = rd_c;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
`ifdef ID_WB_BYPASS_EN
    end else if (valid_q) begin
      // Refresh held operands so EX sees write-backs that land during a hold
      if (wb_we_c && wb_tgt_c == rs1_q) r_data1_d = wb_data;
      if (wb_we_c && wb_tgt_c == rs2_q) r_data2_d = wb_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      r_data1_q <= '0;
      r_data2_q <= '0;
      ex_data_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      r_data1_q <= r_data1_d;
      r_data2_q <= r_data2_d;
      ex_data_q <= ex_data_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_r_data1 = r_data1_q;
  assign out_r_data2 = r_data2_q;
  assign out_ex_data = ex_data_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_rd      = rd_q;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed scoreboard bench for id_pipe_stage; expectations follow ID_WB_BYPASS_EN.
module tb_id_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        Reg2Loc;
  logic        wb_RegWrite, wb_WRegLoc;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        ex_MemRead;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_r_data1, out_r_data2, out_ex_data;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] pc, r1, r2, imm;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model [32];

  always #5 clk = ~clk;

  id_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .Reg2Loc(Reg2Loc),
    .wb_RegWrite(wb_RegWrite), .wb_WRegLoc(wb_WRegLoc), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_r_data1(out_r_data1), .out_r_data2(out_r_data2),
    .out_ex_data(out_ex_data), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .stall(stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rd_model(input logic [4:0] idx);
    return (idx == 5'd31) ? 64'd0 : model[idx];
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
    return {10'b1001000100, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    return {11'b10001011000, rm, 6'd0, rn, rd};
  endfunction

  task automatic wb_write(input logic loc, input logic [4:0] r, input logic [63:0] d);
    logic [4:0] tgt;
    wb_RegWrite = 1'b1; wb_WRegLoc = loc; wb_reg = r; wb_data = d;
    tick();
    wb_RegWrite = 1'b0; wb_WRegLoc = 1'b0;
    tgt = loc ? 5'd30 : r;
    if (tgt != 5'd31) model[tgt] = d;
  endtask

  // Present one instruction, wait (bounded) for acceptance, push the expectation
  task automatic issue(input logic [31:0] i, input logic r2l, input logic [63:0] p, input logic [63:0] imm);
    int   n;
    exp_t e;
    n = 0;
    in_valid = 1'b1; inst = i; Reg2Loc = r2l; pc = p;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("issue_ready", 64'(in_ready), 64'd1);
    if (in_ready) begin
      e.pc  = p;
      e.rs1 = i[9:5];
      e.rs2 = r2l ? i[4:0] : i[20:16];
      e.rd  = i[4:0];
      e.r1  = rd_model(e.rs1);
      e.r2  = rd_model(e.rs2);
      e.imm = imm;
      sb_q.push_back(e);
      tick();
      chk("latency_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_pc"},    out_pc,      sb_q[0].pc);
    chk({tag, "_r1"},    out_r_data1, sb_q[0].r1);
    chk({tag, "_r2"},    out_r_data2, sb_q[0].r2);
    chk({tag, "_imm"},   out_ex_data, sb_q[0].imm);
    chk({tag, "_rs1"},   64'(out_rs1), 64'(sb_q[0].rs1));
    chk({tag, "_rd"},    64'(out_rd),  64'(sb_q[0].rd));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_pc"},    out_pc,      64'd0);
    chk({tag, "_r1"},    out_r_data1, 64'd0);
    chk({tag, "_r2"},    out_r_data2, 64'd0);
    chk({tag, "_imm"},   out_ex_data, 64'd0);
    chk({tag, "_idx"},   64'({out_rs1, out_rs2, out_rd}), 64'd0);
  endtask

  // EX side: every consumed ID/EX entry is compared with the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_pc",  out_pc,      e.pc);
        chk("sb_r1",  out_r_data1, e.r1);
        chk("sb_r2",  out_r_data2, e.r2);
        chk("sb_imm", out_ex_data, e.imm);
        chk("sb_rs1", 64'(out_rs1), 64'(e.rs1));
        chk("sb_rs2", 64'(out_rs2), 64'(e.rs2));
        chk("sb_rd",  64'(out_rd),  64'(e.rd));
      end
    end
  end

  initial begin
    logic [31:0] i_st;
    for (int k = 0; k < 32; k++) model[k] = 64'd0;
    rst = 1'b1; in_valid = 1'b0; inst = '0; pc = '0; Reg2Loc = 1'b0;
    wb_RegWrite = 1'b0; wb_WRegLoc = 1'b0; wb_reg = '0; wb_data = '0;
    ex_MemRead = 1'b0; ex_rd = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_stall", 64'(stall), 64'd0);

    // ADDI X1, X2, #5 with X2 = 7
    wb_write(1'b0, 5'd2, 64'd7);
    issue(enc_addi(5'd1, 5'd2, 12'd5), 1'b0, 64'h1000, 64'd5);
    chk("addi_r1", out_r_data1, 64'd7);
    chk("addi_imm", out_ex_data, 64'd5);
    chk("addi_rd", 64'(out_rd), 64'd1);

    // Zero register ignores writes; WRegLoc redirects to the link register
    wb_write(1'b0, 5'd31, 64'hFF);
    wb_write(1'b1, 5'd5, 64'h40);
    issue(enc_add(5'd6, 5'd31, 5'd30), 1'b0, 64'h1004, 64'd0);
    chk("zr_read", out_r_data1, 64'd0);
    chk("lr_read", out_r_data2, 64'h40);
    issue(enc_add(5'd7, 5'd5, 5'd5), 1'b0, 64'h1008, 64'd0);

    // Immediate formats, back to back
    issue({8'b10110100, 19'h7FFFC, 5'd5}, 1'b1, 64'h100C, 64'hFFFF_FFFF_FFFF_FFFC);
    issue({11'b11111000010, 9'h1FF, 2'b00, 5'd4, 5'd9}, 1'b1, 64'h1010, 64'hFFFF_FFFF_FFFF_FFFF);
    issue({6'b000101, 26'd1}, 1'b0, 64'h1014, 64'd1);
    issue({9'b110100101, 2'b00, 16'hABCD, 5'd8}, 1'b0, 64'h1018, 64'h0000_0000_0000_ABCD);

    // Load-use stall on rs1, then on rs2, then released
    wb_write(1'b0, 5'd3, 64'h33);
    wait_drain();
    i_st = enc_add(5'd4, 5'd3, 5'd0);
    in_valid = 1'b1; inst = i_st; Reg2Loc = 1'b0; pc = 64'h2000;
    ex_MemRead = 1'b1; ex_rd = 5'd3;
    #1;
    chk("stall_rs1", 64'(stall), 64'd1);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("stall_bubble", 64'(out_valid), 64'd0);
    inst = enc_add(5'd4, 5'd1, 5'd3);
    #1;
    chk("stall_rs2", 64'(stall), 64'd1);
    ex_MemRead = 1'b0;
    issue(i_st, 1'b0, 64'h2000, 64'd0);
    ex_MemRead = 1'b1; ex_rd = 5'd31;
    issue(enc_addi(5'd1, 5'd31, 12'd0), 1'b0, 64'h2004, 64'd0);
    ex_MemRead = 1'b0;

    // Hold for 3 cycles with a write-back to X2 in the middle
    wait_drain();
    out_ready = 1'b0;
    issue(enc_addi(5'd1, 5'd2, 12'd5), 1'b0, 64'h3000, 64'd5);
    tick();
    chk_held("hold0");
    wb_write(1'b0, 5'd2, 64'd9);
`ifdef ID_WB_BYPASS_EN
    sb_q[0].r1 = 64'd9;
    chk("hold_wb_r1", out_r_data1, 64'd9);
`else
    chk("hold_wb_r1", out_r_data1, 64'd7);
`endif
    chk_held("hold1");
    tick();
    chk_held("hold2");
    out_ready = 1'b1;
    wait_drain();

    // Flush with a valid input and a valid (held) output
    out_ready = 1'b0;
    issue(enc_add(5'd9, 5'd2, 5'd3), 1'b0, 64'h4000, 64'd0);
    in_valid = 1'b1; inst = enc_addi(5'd1, 5'd2, 12'd1); pc = 64'h4004; flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    void'(sb_q.pop_front());
    out_ready = 1'b1;

    // Reset in the middle of a hold drops everything
    out_ready = 1'b0;
    issue(enc_addi(5'd11, 5'd3, 12'd7), 1'b0, 64'h5000, 64'd7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 32; k++) model[k] = 64'd0;
    chk_all_zero("rst_hold");
    out_ready = 1'b1;
    issue({6'b000101, 26'd1}, 1'b0, 64'h6000, 64'd1);

    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
